// File: rtl/deserializer.sv
// rtl/deserializer.sv - LSB-first bit-serial to parallel word receiver with one-entry output register
module deserializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   input  logic                  i_data,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_busy,
   output logic                  o_frame_err,
   output logic                  o_overrun
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] sr_q, sr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  frame_err_q, frame_err_d;
   logic                  overrun_q, overrun_d;
   logic [DATA_WIDTH-1:0] word;
   logic                  complete;

   // State register: cnt is the FSM state (0 = IDLE, otherwise SHIFT).
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         cnt_q       <= '0;
         sr_q        <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // Next-state logic: bit capture, word completion and abort.
   always_comb begin
      cnt_d       = cnt_q;
      sr_d        = sr_q;
      frame_err_d = 1'b0;
      word        = {i_data, sr_q[DATA_WIDTH-1:1]};
      complete    = i_valid && (cnt_q == LAST);
      if (i_valid) begin
         sr_d  = word;
         cnt_d = complete ? '0 : cnt_q + 1'b1;
      end else if (cnt_q != '0) begin
         cnt_d       = '0;
         frame_err_d = 1'b1;
      end
   end

   // Output register: a consume and a load on the same edge leave o_valid set.
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end
      if (complete) begin
         if (!valid_q || i_ready) begin
            data_d  = word;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_busy      = (cnt_q != '0);
   assign o_frame_err = frame_err_q;
   assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - scoreboard bench for deserializer
module tb_deserializer;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_valid = 1'b0;
   logic       i_data = 1'b0;
   logic       i_ready = 1'b0;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_busy;
   logic       o_frame_err;
   logic       o_overrun;

   int         n_checks = 0;
   int         n_fails = 0;
   int         fe_seen = 0;
   int         ov_seen = 0;
   logic [7:0] exp_q[$];

   deserializer #(.DATA_WIDTH(8)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
      .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy),
      .o_frame_err(o_frame_err), .o_overrun(o_overrun)
   );

   always #5 i_clk = ~i_clk;

   // Scoreboard: a handshake is certain at the next rising edge when seen here.
   always @(negedge i_clk) begin
      if (o_frame_err) fe_seen++;
      if (o_overrun) ov_seen++;
      if (i_rst_n && o_valid && i_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL scoreboard_unexpected got=%h required=none", o_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (o_data !== e) begin
               n_fails++;
               $display("FAIL scoreboard_word got=%h required=%h", o_data, e);
            end
         end
      end
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] w, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         i_valid = 1'b1;
         i_data  = w[i];
         step();
      end
      i_valid = 1'b0;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      step();
      step();
      n_checks += 5;
      if (o_data !== 8'h00)   begin n_fails++; $display("FAIL reset_data got=%h required=00", o_data); end
      if (o_valid !== 1'b0)   begin n_fails++; $display("FAIL reset_valid got=%b required=0", o_valid); end
      if (o_busy !== 1'b0)    begin n_fails++; $display("FAIL reset_busy got=%b required=0", o_busy); end
      if (o_frame_err !== 1'b0) begin n_fails++; $display("FAIL reset_frame_err got=%b required=0", o_frame_err); end
      if (o_overrun !== 1'b0) begin n_fails++; $display("FAIL reset_overrun got=%b required=0", o_overrun); end
      i_rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_word();
      logic [7:0] w;
      w = 8'hA5;
      i_ready = 1'b1;
      exp_q.push_back(w);
      for (int i = 0; i < 8; i++) begin
         i_valid = 1'b1;
         i_data  = w[i];
         step();
         if (i < 7) begin
            n_checks += 2;
            if (o_busy !== 1'b1)  begin n_fails++; $display("FAIL single_busy bit=%0d got=%b required=1", i, o_busy); end
            if (o_valid !== 1'b0) begin n_fails++; $display("FAIL single_early_valid bit=%0d got=%b required=0", i, o_valid); end
         end
      end
      i_valid = 1'b0;
      n_checks += 3;
      if (o_valid !== 1'b1) begin n_fails++; $display("FAIL single_valid got=%b required=1", o_valid); end
      if (o_data !== 8'hA5) begin n_fails++; $display("FAIL single_data got=%h required=a5", o_data); end
      if (o_busy !== 1'b0)  begin n_fails++; $display("FAIL single_busy_fall got=%b required=0", o_busy); end
      step();
      n_checks++;
      if (o_valid !== 1'b0) begin n_fails++; $display("FAIL single_valid_one_cycle got=%b required=0", o_valid); end
   endtask

   task automatic test_back_to_back();
      int fe0, ov0;
      logic [7:0] words [4];
      words = '{8'h01, 8'h80, 8'h12, 8'h34};
      fe0 = fe_seen;
      ov0 = ov_seen;
      i_ready = 1'b1;
      exp_q.push_back(words[0]);
      send_bits(words[0], 8);
      step();
      exp_q.push_back(words[1]);
      send_bits(words[1], 8);
      exp_q.push_back(words[2]);
      send_bits(words[2], 8);
      exp_q.push_back(words[3]);
      send_bits(words[3], 8);
      step();
      step();
      n_checks += 3;
      if (exp_q.size() != 0)  begin n_fails++; $display("FAIL b2b_words_left got=%0d required=0", exp_q.size()); end
      if (fe_seen != fe0)     begin n_fails++; $display("FAIL b2b_frame_err got=%0d required=%0d", fe_seen, fe0); end
      if (ov_seen != ov0)     begin n_fails++; $display("FAIL b2b_overrun got=%0d required=%0d", ov_seen, ov0); end
   endtask

   task automatic test_backpressure();
      int ov0;
      ov0 = ov_seen;
      i_ready = 1'b0;
      exp_q.push_back(8'h3C);
      send_bits(8'h3C, 8);
      send_bits(8'hC3, 8);
      n_checks += 3;
      if (o_overrun !== 1'b1) begin n_fails++; $display("FAIL bp_overrun_pulse got=%b required=1", o_overrun); end
      if (o_data !== 8'h3C)   begin n_fails++; $display("FAIL bp_data_held got=%h required=3c", o_data); end
      if (o_valid !== 1'b1)   begin n_fails++; $display("FAIL bp_valid_held got=%b required=1", o_valid); end
      step();
      n_checks += 2;
      if (o_overrun !== 1'b0) begin n_fails++; $display("FAIL bp_overrun_width got=%b required=0", o_overrun); end
      if (ov_seen != ov0 + 1) begin n_fails++; $display("FAIL bp_overrun_count got=%0d required=%0d", ov_seen, ov0 + 1); end
      i_ready = 1'b1;
      step();
      n_checks += 2;
      if (o_valid !== 1'b0)   begin n_fails++; $display("FAIL bp_release_valid got=%b required=0", o_valid); end
      if (exp_q.size() != 0)  begin n_fails++; $display("FAIL bp_words_left got=%0d required=0", exp_q.size()); end
      i_ready = 1'b0;
   endtask

   task automatic test_simultaneous();
      int ov0;
      logic [7:0] w;
      ov0 = ov_seen;
      i_ready = 1'b0;
      exp_q.push_back(8'h11);
      send_bits(8'h11, 8);
      step();
      w = 8'h22;
      exp_q.push_back(w);
      send_bits(w, 7);
      i_valid = 1'b1;
      i_data  = w[7];
      i_ready = 1'b1;
      step();
      i_valid = 1'b0;
      n_checks += 3;
      if (o_data !== 8'h22)   begin n_fails++; $display("FAIL simul_data got=%h required=22", o_data); end
      if (o_valid !== 1'b1)   begin n_fails++; $display("FAIL simul_valid got=%b required=1", o_valid); end
      if (o_overrun !== 1'b0) begin n_fails++; $display("FAIL simul_overrun got=%b required=0", o_overrun); end
      step();
      n_checks += 3;
      if (o_valid !== 1'b0)   begin n_fails++; $display("FAIL simul_drain got=%b required=0", o_valid); end
      if (ov_seen != ov0)     begin n_fails++; $display("FAIL simul_overrun_count got=%0d required=%0d", ov_seen, ov0); end
      if (exp_q.size() != 0)  begin n_fails++; $display("FAIL simul_words_left got=%0d required=0", exp_q.size()); end
   endtask

   task automatic test_framing();
      int fe0;
      fe0 = fe_seen;
      i_ready = 1'b1;
      send_bits(8'h07, 3);
      n_checks++;
      if (o_busy !== 1'b1)      begin n_fails++; $display("FAIL frame_busy_before got=%b required=1", o_busy); end
      step();
      n_checks += 2;
      if (o_frame_err !== 1'b1) begin n_fails++; $display("FAIL frame_err_pulse got=%b required=1", o_frame_err); end
      if (o_busy !== 1'b0)      begin n_fails++; $display("FAIL frame_busy_fall got=%b required=0", o_busy); end
      exp_q.push_back(8'h5A);
      send_bits(8'h5A, 8);
      n_checks += 3;
      if (o_valid !== 1'b1)     begin n_fails++; $display("FAIL frame_next_valid got=%b required=1", o_valid); end
      if (o_data !== 8'h5A)     begin n_fails++; $display("FAIL frame_next_data got=%h required=5a", o_data); end
      if (fe_seen != fe0 + 1)   begin n_fails++; $display("FAIL frame_err_count got=%0d required=%0d", fe_seen, fe0 + 1); end
      step();
   endtask

   task automatic test_reset_midword();
      int fe0, ov0;
      fe0 = fe_seen;
      ov0 = ov_seen;
      i_ready = 1'b1;
      send_bits(8'hFF, 5);
      i_rst_n = 1'b0;
      step();
      i_rst_n = 1'b1;
      n_checks += 4;
      if (o_busy !== 1'b0)      begin n_fails++; $display("FAIL rstmid_busy got=%b required=0", o_busy); end
      if (o_valid !== 1'b0)     begin n_fails++; $display("FAIL rstmid_valid got=%b required=0", o_valid); end
      if (o_data !== 8'h00)     begin n_fails++; $display("FAIL rstmid_data got=%h required=00", o_data); end
      if (o_frame_err !== 1'b0) begin n_fails++; $display("FAIL rstmid_frame_err got=%b required=0", o_frame_err); end
      exp_q.push_back(8'h0F);
      send_bits(8'h0F, 8);
      n_checks += 3;
      if (o_data !== 8'h0F)     begin n_fails++; $display("FAIL rstmid_word got=%h required=0f", o_data); end
      if (o_valid !== 1'b1)     begin n_fails++; $display("FAIL rstmid_word_valid got=%b required=1", o_valid); end
      if (fe_seen != fe0 || ov_seen != ov0) begin
         n_fails++;
         $display("FAIL rstmid_pulses got=fe%0d/ov%0d required=fe%0d/ov%0d", fe_seen, ov_seen, fe0, ov0);
      end
      step();
      step();
      n_checks++;
      if (exp_q.size() != 0)    begin n_fails++; $display("FAIL rstmid_words_left got=%0d required=0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_backpressure();
      test_simultaneous();
      test_framing();
      test_reset_midword();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
